id_stage_pipe: RTL and testbench
================================

# id_stage_pipe

Parametrised successor to the 16-bit decode stage. It decodes one instruction per cycle from IF and reads operands from an internal register file with WB write-through bypass. It detects load-use hazards and inserts a single bubble. Results are held in a registered ID/EX pipeline slot, which IF and EX reach through valid/ready handshakes with flush support.

## Interface
- DATA_W, 16, register/operand/immediate width (≥ 8)
- NREG, 16, implemented registers (2..16); indices ≥ NREG read 0, writes ignored
- R0_ZERO, 1, when 1 r0 reads 0 and writes to r0 are ignored
- PC_W, 16, program counter width
- LOAD_OPC, 4'hA, opcode treated as a load for hazard detection
- IMM8_MASK, 16'h0000, bit k set: opcode k uses 8-bit immediate instr[7:0], else 4-bit instr[3:0]
- clk  in  1  clock; one clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  IF presents an instruction
- in_ready  out  1  ID accepts this cycle
- in_instr  in  16  instruction: [15:12] opcode, [11:8] rd, [7:4] rs1, [3:0] rs2
- in_pc  in  PC_W  instruction PC
- flush  in  1  squash the ID/EX slot (taken branch)
- wb_reg_write  in  1  WB write enable
- wb_rd  in  4  WB destination
- wb_rd_data  in  DATA_W  WB data
- out_valid  out  1  ID/EX slot holds an instruction
- out_ready  in  1  EX accepts the slot
- out_opcode, out_rd, out_rs1, out_rs2  out  4 each  registered decode fields
- out_rs1_data, out_rs2_data  out  DATA_W  registered operands
- out_imm  out  DATA_W  sign-extended immediate
- out_pc  out  PC_W  registered PC
- hazard_stall  out  1  combinational; load-use bubble being inserted this cycle

## Operation
- Register file: NREG × DATA_W. A write is effective when wb_reg_write && wb_rd<NREG && !(R0_ZERO && wb_rd==0). Combinational reads. If a read index equals an effective same-cycle wb_rd, the read returns wb_rd_data (write-through bypass).
- slot_free = !out_valid || out_ready.
- hazard = out_valid && out_opcode==LOAD_OPC && !(R0_ZERO && out_rd==0) && (out_rd==in_instr[7:4] || out_rd==in_instr[3:0]). Evaluated only when in_valid.
- hazard_stall = in_valid && hazard && slot_free && !flush.
- in_ready = flush || (slot_free && !hazard).
- Slot update per edge, in priority order:
  - flush: out_valid←0. Any in_valid beat this cycle is consumed and discarded.
  - in_valid && in_ready: slot loads the decoded fields, bypassed operands, immediate and PC; out_valid←1.
  - slot_free && !accept: out_valid←0. A hazard therefore yields one bubble.
  - held (out_valid && !out_ready): fields are unchanged. Operand refresh: if an effective WB write targets out_rs1 (or out_rs2), that operand register takes wb_rd_data, so a stalled slot never carries stale data.
- Immediate: IMM8_MASK[opcode] ? sext(instr[7:0]) : sext(instr[3:0]), to DATA_W.
- Reset (async, immediate): out_valid=0; all out_* fields, operands, imm and pc =0; all registers =0. in_ready=1 and hazard_stall=0 follow combinationally.

## Timing
- Decode latency is 1 cycle: an instruction accepted at edge N appears on out_* after edge N.
- Throughput is 1 per cycle when out_ready stays 1 and no hazard occurs.
- A load-use costs exactly 1 bubble cycle. The dependent instruction is accepted on the following edge, because the load has left the slot.
- A WB write in the same cycle as acceptance is visible in the captured operands (bypass).
- Flush is effective at the next edge, and flush beats a hazard.
- rst deasserted mid-stream: the first edge after deassertion behaves as from an empty slot.

## Test plan
- Reset then stream: write r1=0x0011 and r2=0x0022 via WB, then send ADD rd=3, rs1=1, rs2=2. Expect out_rs1_data=0x0011 and out_rs2_data=0x0022 one cycle later, out_valid=1, and back-to-back acceptance at 1 per cycle.
- Bypass: WB writes r5=0xBEEF in the same cycle that an instruction reading rs1=5 is accepted. Expect out_rs1_data=0xBEEF.
- Load-use: LOAD rd=4, then an instruction with rs2=4. Expect hazard_stall=1 and in_ready=0 for one cycle, one out_valid=0 bubble, then the dependent instruction accepted. A LOAD with rd=0 and R0_ZERO=1 produces no stall.
- Backpressure refresh: hold out_ready=0 with the slot holding rs1=7. WB writes r7=0x1234. Expect out_rs1_data=0x1234 while the other fields are unchanged and in_ready=0.
- Flush: flush=1 with out_valid=1 and in_valid=1. Expect out_valid=0 next cycle, the incoming beat discarded, and in_ready=1.
- Params: NREG=8, IMM8_MASK bit 3 set. Expect opcode 3 with instr[7:0]=0x80 to give out_imm=0xFF80, a read of r12 to return 0, and a write to r12 to be ignored.

Source files
------------

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: instruction decode stage with an internal register file,
// WB write-through bypass, load-use bubble insertion and a registered
// ID/EX slot.
//
// Handshakes: a beat moves across an interface on a rising edge when both
// valid and ready are high in the cycle before it. in_ready never depends
// on in_valid except through the hazard term; out_valid never drops
// without a transfer unless flush squashes the slot. flush beats all else:
// the slot empties and any incoming beat that cycle is taken and dropped.
module id_stage_pipe #(
   parameter int          DATA_W    = 16,
   parameter int          NREG      = 16,
   parameter bit          R0_ZERO   = 1'b1,
   parameter int          PC_W      = 16,
   parameter logic [3:0]  LOAD_OPC  = 4'hA,
   parameter logic [15:0] IMM8_MASK = 16'h0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [15:0]       in_instr,
   input  logic [PC_W-1:0]   in_pc,
   input  logic              flush,
   input  logic              wb_reg_write,
   input  logic [3:0]        wb_rd,
   input  logic [DATA_W-1:0] wb_rd_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [3:0]        out_opcode,
   output logic [3:0]        out_rd,
   output logic [3:0]        out_rs1,
   output logic [3:0]        out_rs2,
   output logic [DATA_W-1:0] out_rs1_data,
   output logic [DATA_W-1:0] out_rs2_data,
   output logic [DATA_W-1:0] out_imm,
   output logic [PC_W-1:0]   out_pc,
   output logic              hazard_stall
);

   localparam logic [4:0] NREG_L = 5'(NREG);

   logic [DATA_W-1:0] r_regs [NREG];

   logic              r_out_valid;
   logic [3:0]        r_opcode;
   logic [3:0]        r_rd;
   logic [3:0]        r_rs1;
   logic [3:0]        r_rs2;
   logic [DATA_W-1:0] r_rs1_data;
   logic [DATA_W-1:0] r_rs2_data;
   logic [DATA_W-1:0] r_imm;
   logic [PC_W-1:0]   r_pc;

   logic              w_wb_eff;
   logic              w_slot_free;
   logic              w_hazard;
   logic              w_accept;
   logic [DATA_W-1:0] w_rs1_val;
   logic [DATA_W-1:0] w_rs2_val;
   logic [DATA_W-1:0] w_imm;

   // A WB write only counts if it targets an implemented, writable register
   assign w_wb_eff = wb_reg_write && ({1'b0, wb_rd} < NREG_L) &&
                     !(R0_ZERO && (wb_rd == 4'd0));

   assign w_slot_free = !r_out_valid || out_ready;

   // Load in the slot whose destination feeds either source of the incoming beat
   assign w_hazard = in_valid && r_out_valid && (r_opcode == LOAD_OPC) &&
                     !(R0_ZERO && (r_rd == 4'd0)) &&
                     ((r_rd == in_instr[7:4]) || (r_rd == in_instr[3:0]));

   assign in_ready     = flush || (w_slot_free && !w_hazard);
   assign hazard_stall = in_valid && w_hazard && w_slot_free && !flush;
   assign w_accept     = in_valid && in_ready;

   assign w_imm = IMM8_MASK[in_instr[15:12]] ? DATA_W'($signed(in_instr[7:0]))
                                             : DATA_W'($signed(in_instr[3:0]));

   // Operand read: unimplemented indices give 0, same-cycle WB write wins
   always_comb begin
      w_rs1_val = '0;
      w_rs2_val = '0;
      for (int k = 0; k < NREG; k++) begin
         if (in_instr[7:4] == 4'(k)) w_rs1_val = r_regs[k];
         if (in_instr[3:0] == 4'(k)) w_rs2_val = r_regs[k];
      end
      if (w_wb_eff && (wb_rd == in_instr[7:4])) w_rs1_val = wb_rd_data;
      if (w_wb_eff && (wb_rd == in_instr[3:0])) w_rs2_val = wb_rd_data;
   end

   // Register file write port
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < NREG; k++) r_regs[k] <= '0;
      end else if (w_wb_eff) begin
         for (int k = 0; k < NREG; k++) begin
            if (wb_rd == 4'(k)) r_regs[k] <= wb_rd_data;
         end
      end
   end

   // ID/EX slot: flush, then load, then drain, else hold with operand refresh
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_opcode    <= '0;
         r_rd        <= '0;
         r_rs1       <= '0;
         r_rs2       <= '0;
         r_rs1_data  <= '0;
         r_rs2_data  <= '0;
         r_imm       <= '0;
         r_pc        <= '0;
      end else if (flush) begin
         r_out_valid <= 1'b0;
      end else if (w_accept) begin
         r_out_valid <= 1'b1;
         r_opcode    <= in_instr[15:12];
         r_rd        <= in_instr[11:8];
         r_rs1       <= in_instr[7:4];
         r_rs2       <= in_instr[3:0];
         r_rs1_data  <= w_rs1_val;
         r_rs2_data  <= w_rs2_val;
         r_imm       <= w_imm;
         r_pc        <= in_pc;
      end else if (w_slot_free) begin
         r_out_valid <= 1'b0;
      end else begin
         if (w_wb_eff && (wb_rd == r_rs1)) r_rs1_data <= wb_rd_data;
         if (w_wb_eff && (wb_rd == r_rs2)) r_rs2_data <= wb_rd_data;
      end
   end

   assign out_valid    = r_out_valid;
   assign out_opcode   = r_opcode;
   assign out_rd       = r_rd;
   assign out_rs1      = r_rs1;
   assign out_rs2      = r_rs2;
   assign out_rs1_data = r_rs1_data;
   assign out_rs2_data = r_rs2_data;
   assign out_imm      = r_imm;
   assign out_pc       = r_pc;

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe: directed bench for id_stage_pipe built with NREG=8 and
// opcode 3 using the 8-bit immediate.
module tb_id_stage_pipe;

   localparam int EW = 80;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_instr;
   logic [15:0] in_pc;
   logic        flush;
   logic        wb_reg_write;
   logic [3:0]  wb_rd;
   logic [15:0] wb_rd_data;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  out_opcode;
   logic [3:0]  out_rd;
   logic [3:0]  out_rs1;
   logic [3:0]  out_rs2;
   logic [15:0] out_rs1_data;
   logic [15:0] out_rs2_data;
   logic [15:0] out_imm;
   logic [15:0] out_pc;
   logic        hazard_stall;

   // cycle probe requested by the stimulus, checked by the monitor
   logic        pr_en;
   logic        pr_in_ready;
   logic        pr_stall;
   logic        pr_out_valid;
   logic        pr_rs_en;
   logic [15:0] pr_rs1;
   logic        end_chk;

   logic [EW-1:0] exp_q[$];
   int n_vec = 0;
   int n_err = 0;

   id_stage_pipe #(
      .DATA_W(16), .NREG(8), .R0_ZERO(1'b1), .PC_W(16),
      .LOAD_OPC(4'hA), .IMM8_MASK(16'h0008)
   ) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .flush(flush),
      .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_rd_data(wb_rd_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_opcode(out_opcode), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
      .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
      .out_imm(out_imm), .out_pc(out_pc),
      .hazard_stall(hazard_stall)
   );

   // clock
   always #5 clk = ~clk;

   // ---------------- monitor / scoreboard ----------------
   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      logic [EW-1:0] got;
      logic [EW-1:0] exp;
      if (pr_en) begin
         chk("in_ready", {31'b0, in_ready}, {31'b0, pr_in_ready});
         chk("hazard_stall", {31'b0, hazard_stall}, {31'b0, pr_stall});
         chk("out_valid", {31'b0, out_valid}, {31'b0, pr_out_valid});
      end
      if (pr_rs_en) chk("out_rs1_data", {16'b0, out_rs1_data}, {16'b0, pr_rs1});
      if (!rst && out_valid && out_ready) begin
         got = {out_opcode, out_rd, out_rs1, out_rs2,
                out_rs1_data, out_rs2_data, out_imm, out_pc};
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL slot_unexpected: got %h expected no transfer", got);
         end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
               n_err++;
               $display("FAIL slot: got %h expected %h (op/rd/rs1/rs2 d1 d2 imm pc) at %0t",
                        got, exp, $time);
            end
         end
      end
      if (end_chk) chk("leftover_slots", exp_q.size(), 0);
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
      in_valid     = 1'b0;
      flush        = 1'b0;
      wb_reg_write = 1'b0;
      pr_en        = 1'b0;
      pr_rs_en     = 1'b0;
   endtask

   task automatic issue(input logic [15:0] instr, input logic [15:0] pc);
      in_valid = 1'b1;
      in_instr = instr;
      in_pc    = pc;
   endtask

   task automatic wb(input logic [3:0] rd, input logic [15:0] d);
      wb_reg_write = 1'b1;
      wb_rd        = rd;
      wb_rd_data   = d;
   endtask

   task automatic probe(input logic rdy, input logic stl, input logic ov);
      pr_en        = 1'b1;
      pr_in_ready  = rdy;
      pr_stall     = stl;
      pr_out_valid = ov;
   endtask

   task automatic expect_slot(input logic [15:0] instr, input logic [15:0] d1,
                              input logic [15:0] d2, input logic [15:0] imm,
                              input logic [15:0] pc);
      exp_q.push_back({instr, d1, d2, imm, pc});
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0;
      wb_reg_write = 1'b0; wb_rd = '0; wb_rd_data = '0; out_ready = 1'b1;
      pr_en = 1'b0; pr_in_ready = 1'b0; pr_stall = 1'b0; pr_out_valid = 1'b0;
      pr_rs_en = 1'b0; pr_rs1 = '0; end_chk = 1'b0;
      tick();
      // reset state
      probe(1, 0, 0); pr_rs_en = 1'b1; pr_rs1 = 16'h0000;
      tick();
      rst = 1'b0;

      // preload r1, r2
      wb(4'd1, 16'h0011); probe(1, 0, 0); tick();
      wb(4'd2, 16'h0022); tick();

      // back-to-back stream
      issue(16'h1312, 16'h0100); expect_slot(16'h1312, 16'h0011, 16'h0022, 16'h0002, 16'h0100);
      probe(1, 0, 0); tick();
      issue(16'h2421, 16'h0102); expect_slot(16'h2421, 16'h0022, 16'h0011, 16'h0001, 16'h0102);
      probe(1, 0, 1); tick();

      // same-cycle WB bypass
      issue(16'h1650, 16'h0104); wb(4'd5, 16'hBEEF);
      expect_slot(16'h1650, 16'hBEEF, 16'h0000, 16'h0000, 16'h0104);
      probe(1, 0, 1); tick();

      // load-use: one stall, one bubble, then accept with WB bypass
      issue(16'hA410, 16'h0106); expect_slot(16'hA410, 16'h0011, 16'h0000, 16'h0000, 16'h0106);
      probe(1, 0, 1); tick();
      issue(16'h1504, 16'h0108); probe(0, 1, 1); tick();
      issue(16'h1504, 16'h0108); wb(4'd4, 16'h4444);
      expect_slot(16'h1504, 16'h0000, 16'h4444, 16'h0004, 16'h0108);
      probe(1, 0, 0); tick();

      // load to r0 does not stall
      issue(16'hA010, 16'h010A); expect_slot(16'hA010, 16'h0011, 16'h0000, 16'h0000, 16'h010A);
      probe(1, 0, 1); tick();
      issue(16'h1700, 16'h010C); expect_slot(16'h1700, 16'h0000, 16'h0000, 16'h0000, 16'h010C);
      probe(1, 0, 1); tick();

      // backpressure with operand refresh of rs1=7
      issue(16'h1370, 16'h010E); expect_slot(16'h1370, 16'h1234, 16'h0000, 16'h0000, 16'h010E);
      probe(1, 0, 1); tick();
      out_ready = 1'b0; wb(4'd7, 16'h1234); probe(0, 0, 1); tick();
      issue(16'h2111, 16'h0110); probe(0, 0, 1); pr_rs_en = 1'b1; pr_rs1 = 16'h1234; tick();
      out_ready = 1'b1;
      issue(16'h2111, 16'h0110); expect_slot(16'h2111, 16'h0011, 16'h0011, 16'h0001, 16'h0110);
      probe(1, 0, 1); tick();

      // flush with slot full and an incoming beat that gets dropped
      issue(16'h1222, 16'h0112); flush = 1'b1; probe(1, 0, 1); tick();
      probe(1, 0, 0); tick();

      // flush beats a load-use hazard
      issue(16'hA512, 16'h0114); expect_slot(16'hA512, 16'h0011, 16'h0022, 16'h0002, 16'h0114);
      probe(1, 0, 0); tick();
      issue(16'h1350, 16'h0116); flush = 1'b1; probe(1, 0, 1); tick();
      probe(1, 0, 0); tick();

      // NREG=8: r12 reads 0, writes to r12 and r0 ignored; immediates
      issue(16'h21C0, 16'h0118); wb(4'd12, 16'h5555);
      expect_slot(16'h21C0, 16'h0000, 16'h0000, 16'h0000, 16'h0118);
      probe(1, 0, 0); tick();
      issue(16'h210C, 16'h011A); expect_slot(16'h210C, 16'h0000, 16'h0000, 16'hFFFC, 16'h011A);
      probe(1, 0, 1); tick();
      issue(16'h3280, 16'h011C); wb(4'd0, 16'h9999);
      expect_slot(16'h3280, 16'h0000, 16'h0000, 16'hFF80, 16'h011C);
      probe(1, 0, 1); tick();
      issue(16'h1008, 16'h011E); expect_slot(16'h1008, 16'h0000, 16'h0000, 16'hFFF8, 16'h011E);
      probe(1, 0, 1); tick();
      issue(16'h3217, 16'h0120); expect_slot(16'h3217, 16'h0011, 16'h1234, 16'h0017, 16'h0120);
      probe(1, 0, 1); tick();
      probe(1, 0, 1); tick();
      probe(1, 0, 0); tick();

      // final report
      end_chk = 1'b1;
      @(posedge clk);
      #1;
      end_chk = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
